// File: rtl/alu_types.sv
// Shared ALU operation encoding used by the decode stage and the ALU.
package alu_types;

  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_ADD  = 4'd3,
    ALU_SUB  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_control_t;

endpackage

// File: rtl/alu_multicycle.sv
// Handshaked multi-cycle ALU: single-cycle logic/arith ops, iterative shifter,
// result and flags held in DONE until the consumer takes them.
module alu_multicycle
  import alu_types::*;
#(
  parameter int unsigned N          = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  alu_control_t control,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         overflow,
  output logic         zero,
  output logic         equal
);

  localparam int unsigned   SW   = $clog2(N);
  localparam logic [SW-1:0] STEP = SW'(SHIFT_STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_in_ready;
  logic          r_out_valid;

  alu_control_t  r_ctl;
  logic [N-1:0]  r_work;
  logic [SW-1:0] r_rem;
  logic          r_eq;
  logic [N-1:0]  r_result;
  logic          r_overflow;
  logic          r_zero;
  logic          r_equal;

  logic          w_accept;
  logic [SW-1:0] w_shamt;
  logic          w_is_shift;
  logic          w_start_shift;
  logic [N-1:0]  w_sum;
  logic [N-1:0]  w_diff;
  logic [N-1:0]  w_alu_res;
  logic          w_alu_ovf;
  logic [SW-1:0] w_step;
  logic [SW-1:0] w_rem_next;
  logic [N-1:0]  w_shifted;

  assign w_accept      = in_valid & r_in_ready;
  assign w_shamt       = b[SW-1:0];
  assign w_is_shift    = (control == ALU_SLL) || (control == ALU_SRL) || (control == ALU_SRA);
  assign w_start_shift = w_is_shift && (w_shamt != '0);

  // Single-cycle result from the live inputs, registered on the accept edge.
  always_comb begin
    w_sum     = a + b;
    w_diff    = a - b;
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (control)
      ALU_AND:  w_alu_res = a & b;
      ALU_OR:   w_alu_res = a | b;
      ALU_XOR:  w_alu_res = a ^ b;
      ALU_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (a[N-1] == b[N-1]) && (w_sum[N-1] != a[N-1]);
      end
      ALU_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = (a[N-1] != b[N-1]) && (w_diff[N-1] != a[N-1]);
      end
      ALU_SLT:  w_alu_res = N'($signed(a) < $signed(b));
      ALU_SLTU: w_alu_res = N'(a < b);
      // Only a zero shift amount takes this path: operand passes through.
      ALU_SLL, ALU_SRL, ALU_SRA: w_alu_res = a;
      default:  w_alu_res = '0;
    endcase
  end

  // One shifter iteration of at most STEP bits; SRA keeps replicating the sign.
  always_comb begin
    w_step     = (r_rem > STEP) ? STEP : r_rem;
    w_rem_next = r_rem - w_step;
    w_shifted  = r_work;
    case (r_ctl)
      ALU_SLL: w_shifted = r_work << w_step;
      ALU_SRL: w_shifted = r_work >> w_step;
      ALU_SRA: w_shifted = N'($signed(r_work) >>> w_step);
      default: w_shifted = r_work;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = w_start_shift ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        if (w_rem_next == '0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (r_out_valid && out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register with handshake flags decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next == S_IDLE);
      r_out_valid <= (w_state_next == S_DONE);
    end
  end

  // Operand capture, shifter iteration and result/flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctl      <= ALU_AND;
      r_work     <= '0;
      r_rem      <= '0;
      r_eq       <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      r_equal    <= 1'b0;
    end else if (w_accept) begin
      r_ctl  <= control;
      r_work <= a;
      r_rem  <= w_shamt;
      r_eq   <= (a == b);
      if (!w_start_shift) begin
        r_result   <= w_alu_res;
        r_overflow <= w_alu_ovf;
        r_zero     <= (w_alu_res == '0);
        r_equal    <= (a == b);
      end
    end else if (r_state == S_SHIFT) begin
      r_work <= w_shifted;
      r_rem  <= w_rem_next;
      if (w_rem_next == '0) begin
        r_result   <= w_shifted;
        r_overflow <= 1'b0;
        r_zero     <= (w_shifted == '0);
        r_equal    <= r_eq;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign overflow  = r_overflow;
  assign zero      = r_zero;
  assign equal     = r_equal;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: three configurations (N=32/step 1, N=32/step 8,
// N=16/step 4) checked against an arithmetic reference model.
module tb_alu_multicycle;
  import alu_types::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         iv   [3];
  logic         ordy [3];
  logic [31:0]  da   [3];
  logic [31:0]  db   [3];
  alu_control_t dc   [3];

  logic        ir0, ov0, of0, z0, e0;
  logic        ir1, ov1, of1, z1, e1;
  logic        ir2, ov2, of2, z2, e2;
  logic [31:0] r0, r1;
  logic [15:0] r2;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] r;
    logic        ov;
    logic        z;
    logic        e;
    int          lat;
    int          acc;
  } exp_t;

  alu_multicycle #(.N(32), .SHIFT_STEP(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .a(da[0]), .b(db[0]),
    .control(dc[0]), .out_valid(ov0), .out_ready(ordy[0]), .result(r0),
    .overflow(of0), .zero(z0), .equal(e0));

  alu_multicycle #(.N(32), .SHIFT_STEP(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .a(da[1]), .b(db[1]),
    .control(dc[1]), .out_valid(ov1), .out_ready(ordy[1]), .result(r1),
    .overflow(of1), .zero(z1), .equal(e1));

  alu_multicycle #(.N(16), .SHIFT_STEP(4)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2), .a(da[2][15:0]), .b(db[2][15:0]),
    .control(dc[2]), .out_valid(ov2), .out_ready(ordy[2]), .result(r2),
    .overflow(of2), .zero(z2), .equal(e2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on nw-bit values.
  function automatic void model(input int nw, input int step, input alu_control_t op,
                                input logic [31:0] ai, input logic [31:0] bi,
                                output logic [31:0] r, output logic ov, output logic z,
                                output logic e, output int lat);
    longint full, ua, ub, sa, sb, res;
    int sh;
    full = longint'(1) << nw;
    ua   = longint'(ai) & (full - 1);
    ub   = longint'(bi) & (full - 1);
    sa   = (ua >= full / 2) ? ua - full : ua;
    sb   = (ub >= full / 2) ? ub - full : ub;
    sh   = int'(ub % longint'(nw));
    ov   = 1'b0;
    res  = 0;
    case (op)
      ALU_AND:  res = ua & ub;
      ALU_OR:   res = ua | ub;
      ALU_XOR:  res = ua ^ ub;
      ALU_ADD: begin res = sa + sb; ov = (res >= full / 2) || (res < -(full / 2)); end
      ALU_SUB: begin res = sa - sb; ov = (res >= full / 2) || (res < -(full / 2)); end
      ALU_SLT:  res = (sa < sb) ? 1 : 0;
      ALU_SLTU: res = (ua < ub) ? 1 : 0;
      ALU_SLL:  res = ua << sh;
      ALU_SRL:  res = ua >> sh;
      ALU_SRA:  res = sa >>> sh;
      default:  res = 0;
    endcase
    lat = 1;
    if ((op == ALU_SLL || op == ALU_SRL || op == ALU_SRA) && sh > 0) lat = 1 + (sh + step - 1) / step;
    r = 32'(res & (full - 1));
    z = (r == 32'd0);
    e = (ua == ub);
  endfunction

  task automatic get_out(input int k, output logic ir, output logic ovl, output logic [31:0] r,
                         output logic of, output logic z, output logic e);
    case (k)
      0:       begin ir = ir0; ovl = ov0; r = r0; of = of0; z = z0; e = e0; end
      1:       begin ir = ir1; ovl = ov1; r = r1; of = of1; z = z1; e = e1; end
      default: begin ir = ir2; ovl = ov2; r = {16'h0, r2}; of = of2; z = z2; e = e2; end
    endcase
  endtask

  // Issue one op, scramble inputs after accept, check latency/result, then release it.
  task automatic run_op(input int k, input int nw, input int step, input alu_control_t op,
                        input logic [31:0] av, input logic [31:0] bv, output logic [31:0] r_obs);
    logic [31:0] er, r;
    logic        eov, ez, ee, ir, ovl, of, z, e;
    int          elat, lat;
    model(nw, step, op, av, bv, er, eov, ez, ee, elat);
    @(negedge clk);
    get_out(k, ir, ovl, r, of, z, e);
    chk("op_in_ready", 32'(ir), 32'd1);
    iv[k] = 1'b1; da[k] = av; db[k] = bv; dc[k] = op; ordy[k] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      iv[k] = 1'b0; da[k] = $urandom; db[k] = $urandom;
      dc[k] = alu_control_t'(4'($urandom_range(0, 9)));
      get_out(k, ir, ovl, r, of, z, e);
    end while (!ovl && lat < 200);
    chk("op_latency", 32'(lat), 32'(elat));
    chk("op_result", r, er);
    chk("op_overflow", 32'(of), 32'(eov));
    chk("op_zero", 32'(z), 32'(ez));
    chk("op_equal", 32'(e), 32'(ee));
    r_obs = r;
    ordy[k] = 1'b1;
    @(negedge clk);
    ordy[k] = 1'b0;
    get_out(k, ir, ovl, r, of, z, e);
    chk("op_release_valid", 32'(ovl), 32'd0);
    chk("op_release_ready", 32'(ir), 32'd1);
  endtask

  // Random traffic with random gaps on both sides, scoreboarded in order.
  task automatic run_random(input int k, input int nw, input int step, input int count);
    exp_t        q[$];
    exp_t        x;
    logic [31:0] r;
    logic        ir, ovl, of, z, e, prev_ovl;
    int          cyc, issued, got, limit;
    alu_control_t op;
    cyc = 0; issued = 0; got = 0; prev_ovl = 1'b0;
    limit = count * 80 + 100;
    while ((issued < count || q.size() != 0) && cyc < limit) begin
      @(negedge clk);
      cyc++;
      get_out(k, ir, ovl, r, of, z, e);
      if (ovl && !prev_ovl) begin
        if (q.size() == 0) chk("rand_spurious_valid", 32'(ovl), 32'd0);
        else               chk("rand_latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
      end
      prev_ovl = ovl;
      ordy[k] = ($urandom_range(0, 2) != 0);
      iv[k]   = (issued < count) && ($urandom_range(0, 2) != 0);
      da[k]   = $urandom;
      db[k]   = ($urandom_range(0, 7) == 0) ? da[k] : $urandom;
      op      = alu_control_t'(4'(($urandom_range(0, 20) == 0) ? 15 : $urandom_range(0, 10)));
      dc[k]   = op;
      if (ovl && ordy[k]) begin
        if (q.size() == 0) begin
          chk("rand_unexpected_output", 32'd1, 32'd0);
        end else begin
          x = q.pop_front();
          chk("rand_result", r, x.r);
          chk("rand_overflow", 32'(of), 32'(x.ov));
          chk("rand_zero", 32'(z), 32'(x.z));
          chk("rand_equal", 32'(e), 32'(x.e));
          got++;
        end
      end
      if (iv[k] && ir) begin
        model(nw, step, op, da[k], db[k], x.r, x.ov, x.z, x.e, x.lat);
        x.acc = cyc;
        q.push_back(x);
        issued++;
      end
    end
    iv[k] = 1'b0; ordy[k] = 1'b0;
    chk("rand_all_issued", 32'(issued), 32'(count));
    chk("rand_all_returned", 32'(got), 32'(issued));
  endtask

  logic [31:0] ro, er, rb, bp_r;
  logic        irr, ovl, ofl, zf, ef, bp_of, bp_z, bp_e, eov, ez, ee;
  int          elat, wait_n;

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; da[k] = '0; db[k] = '0; dc[k] = ALU_AND;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      get_out(k, irr, ovl, ro, ofl, zf, ef);
      chk("reset_in_ready", 32'(irr), 32'd1);
      chk("reset_out_valid", 32'(ovl), 32'd0);
      chk("reset_result", ro, 32'd0);
      chk("reset_overflow", 32'(ofl), 32'd0);
      chk("reset_zero", 32'(zf), 32'd0);
      chk("reset_equal", 32'(ef), 32'd0);
    end
    rst = 1'b1;

    // Directed corner cases.
    run_op(0, 32, 1, ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, ro);
    chk("add_ovf_const", ro, 32'h8000_0000);
    run_op(0, 32, 1, ALU_SUB, 32'h1234_5678, 32'h1234_5678, ro);
    chk("sub_eq_const", ro, 32'h0);
    run_op(0, 32, 1, ALU_SRA, 32'h8000_0000, 32'd31, ro);
    chk("sra_step1_const", ro, 32'hFFFF_FFFF);
    run_op(1, 32, 8, ALU_SRA, 32'h8000_0000, 32'd31, ro);
    chk("sra_step8_const", ro, 32'hFFFF_FFFF);
    run_op(0, 32, 1, ALU_SLL, 32'hDEAD_BEEF, 32'h0000_0020, ro);
    chk("sll_zero_shamt_const", ro, 32'hDEAD_BEEF);
    run_op(0, 32, 1, ALU_SLTU, 32'h1, 32'hFFFF_FFFF, ro);
    chk("sltu_const", ro, 32'h1);
    run_op(0, 32, 1, ALU_SLT, 32'h1, 32'hFFFF_FFFF, ro);
    chk("slt_const", ro, 32'h0);
    run_op(0, 32, 1, alu_control_t'(4'd12), 32'h1234_0000, 32'h0000_5678, ro);
    chk("undef_const", ro, 32'h0);
    run_op(2, 16, 4, ALU_SRL, 32'h0000_8001, 32'h0000_0007, ro);
    chk("srl16_const", ro, 32'h0000_0100);

    // Backpressure: hold DONE while inputs churn; nothing may be accepted.
    @(negedge clk);
    iv[0] = 1'b1; da[0] = 32'hA5A5_0F0F; db[0] = 32'h0FF0_1234; dc[0] = ALU_XOR; ordy[0] = 1'b0;
    model(32, 1, ALU_XOR, 32'hA5A5_0F0F, 32'h0FF0_1234, er, eov, ez, ee, elat);
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
      iv[0] = 1'b0;
      get_out(0, irr, ovl, bp_r, bp_of, bp_z, bp_e);
    end while (!ovl && wait_n < 50);
    chk("bp_result", bp_r, er);
    for (int i = 0; i < 5; i++) begin
      iv[0] = (i % 2 == 0); da[0] = $urandom; db[0] = $urandom; dc[0] = ALU_ADD;
      @(negedge clk);
      get_out(0, irr, ovl, ro, ofl, zf, ef);
      chk("bp_hold_result", ro, bp_r);
      chk("bp_hold_flags", {29'd0, ofl, zf, ef}, {29'd0, bp_of, bp_z, bp_e});
      chk("bp_hold_valid", 32'(ovl), 32'd1);
      chk("bp_hold_in_ready", 32'(irr), 32'd0);
    end
    // Output handshake with a new op already presented: it must wait a cycle.
    ordy[0] = 1'b1; iv[0] = 1'b1; da[0] = 32'h0000_0100; db[0] = 32'h0000_0023; dc[0] = ALU_ADD;
    model(32, 1, ALU_ADD, 32'h0000_0100, 32'h0000_0023, er, eov, ez, ee, elat);
    @(negedge clk);
    ordy[0] = 1'b0;
    get_out(0, irr, ovl, ro, ofl, zf, ef);
    chk("bp_release_valid", 32'(ovl), 32'd0);
    chk("bp_release_in_ready", 32'(irr), 32'd1);
    @(negedge clk);
    iv[0] = 1'b0;
    get_out(0, irr, ovl, ro, ofl, zf, ef);
    chk("bp_next_valid", 32'(ovl), 32'd1);
    chk("bp_next_result", ro, er);
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;

    // Asynchronous reset in the 10th cycle of a long SRA.
    iv[0] = 1'b1; da[0] = 32'h8000_0000; db[0] = 32'd31; dc[0] = ALU_SRA;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (9) @(negedge clk);
    get_out(0, irr, ovl, ro, ofl, zf, ef);
    chk("midop_busy_in_ready", 32'(irr), 32'd0);
    #2 rst = 1'b0;
    #1;
    get_out(0, irr, ovl, ro, ofl, zf, ef);
    chk("async_rst_out_valid", 32'(ovl), 32'd0);
    chk("async_rst_in_ready", 32'(irr), 32'd1);
    chk("async_rst_result", ro, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    get_out(0, irr, ovl, ro, ofl, zf, ef);
    chk("abandoned_no_output", 32'(ovl), 32'd0);
    run_op(0, 32, 1, ALU_ADD, 32'h0000_0005, 32'h0000_0007, ro);
    chk("post_reset_add_const", ro, 32'h0000_000C);

    // Randomized traffic on each configuration.
    run_random(0, 32, 1, 1000);
    run_random(2, 16, 4, 1000);
    run_random(1, 32, 8, 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
